// File: rtl/data_mem_wbuf.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | data_mem_wbuf : MEM-stage data memory, posted-store FIFO write buffer,   |
// |                 zero-latency loads forwarded from youngest buffer hit.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module data_mem_wbuf #(
    parameter int MEM_WORDS  = 1024,
    parameter int WBUF_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          mem_read,
    input  logic                          mem_write,
    input  logic [31:0]                   adr,
    input  logic [31:0]                   wdata,
    output logic [31:0]                   rdata,
    output logic                          stall,
    output logic                          misalign,
    output logic [$clog2(WBUF_DEPTH):0]   wbuf_count,
    output logic                          drained
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam int PW = $clog2(WBUF_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] C_FULL = CW'(WBUF_DEPTH);

    logic [31:0]           mem_array [MEM_WORDS];
    logic [PW-1:0]         head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]         count_q, count_d;
    logic [WBUF_DEPTH-1:0] valid_q, valid_d;
    logic [AW-1:0]         idx_q [WBUF_DEPTH];
    logic [AW-1:0]         idx_d [WBUF_DEPTH];
    logic [31:0]           data_q [WBUF_DEPTH];
    logic [31:0]           data_d [WBUF_DEPTH];

    logic [AW-1:0] w_idx;
    logic          w_is_store, w_is_load, w_drain, w_full, w_enq;
    logic          w_fwd_hit;
    logic [31:0]   w_fwd_data;
    logic          w_unused_adr;

    assign w_idx        = adr[AW+1:2];
    assign w_unused_adr = ^adr[31:AW+2];

    always_comb begin
        misalign   = (mem_read | mem_write) & (adr[1:0] != 2'b00);
        w_is_store = mem_write & ~misalign;
        w_is_load  = mem_read & ~mem_write & ~misalign;
        w_full     = (count_q == C_FULL);
        // loads own the single array port, so any mem_read blocks the drain
        w_drain    = (count_q != '0) & ~mem_read;
        stall      = w_is_store & w_full & ~w_drain;
        w_enq      = w_is_store & ~stall;
        wbuf_count = count_q;
        drained    = (count_q == '0);
    end

    // Walk oldest to youngest so the last match is the youngest store
    always_comb begin
        w_fwd_hit  = 1'b0;
        w_fwd_data = '0;
        for (int k = 0; k < WBUF_DEPTH; k++) begin
            if (valid_q[head_q + PW'(k)] && (idx_q[head_q + PW'(k)] == w_idx)) begin
                w_fwd_hit  = 1'b1;
                w_fwd_data = data_q[head_q + PW'(k)];
            end
        end
        rdata = '0;
        if (w_is_load) begin
            rdata = w_fwd_hit ? w_fwd_data : mem_array[w_idx];
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        valid_d = valid_q;
        idx_d   = idx_q;
        data_d  = data_q;
        if (w_drain) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + 1'b1;
        end
        if (w_enq) begin
            idx_d[tail_q]   = w_idx;
            data_d[tail_q]  = wdata;
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + 1'b1;
        end
        case ({w_enq, w_drain})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        idx_q  <= idx_d;
        data_q <= data_d;
    end

    // Pending stores are discarded on reset, so no drain lands on a reset edge
    always_ff @(posedge clk) begin
        if (rst && w_drain) begin
            mem_array[idx_q[head_q]] <= data_q[head_q];
        end
    end

endmodule
`default_nettype wire
